// File: rtl/pipeline_fifo_buffer_fwft_pkg.sv
// Shared constants and helpers for the first-word-fall-through FIFO.
package pipeline_fifo_buffer_fwft_pkg;

    // Number of bits needed to encode 'value' distinct states (ceil(log2(value))).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pipeline_fifo_buffer_fwft_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
module RAM_Simple_Dual_Port
    import pipeline_fifo_buffer_fwft_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 512,
    parameter              RAMSTYLE   = "M10K",
    localparam int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clock_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WORD_WIDTH-1:0] rd_data_o
);

    (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] rd_data_q;

    // Storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pipeline_fifo_buffer_fwft.sv
// First-word-fall-through FIFO: block RAM backing store in front of a
// two-entry register stage (output register plus one skid entry).
module pipeline_fifo_buffer_fwft
    import pipeline_fifo_buffer_fwft_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned ALMOST_FULL  = DEPTH - 4,
    parameter int unsigned ALMOST_EMPTY = 4,
    parameter              RAMSTYLE     = "M10K",
    localparam int unsigned ADDR_WIDTH  = clog2(DEPTH),
    localparam int unsigned COUNT_WIDTH = clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [WORD_WIDTH-1:0]  input_data,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [WORD_WIDTH-1:0]  output_data,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   almost_full,
    output logic                   almost_empty
);

    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] FULL_LVL  = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] AF_LVL    = COUNT_WIDTH'(ALMOST_FULL);
    localparam logic [COUNT_WIDTH-1:0] AE_LVL    = COUNT_WIDTH'(ALMOST_EMPTY);

    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] ram_cnt_q, ram_cnt_d;
    logic                   rd_pend_q, rd_pend_d;
    logic                   out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [WORD_WIDTH-1:0]  skid_data_q, skid_data_d;
    logic                   in_ready_q, in_ready_d;
    logic                   af_q, af_d;
    logic                   ae_q, ae_d;

    logic                   push;
    logic                   pop;
    logic                   room;
    logic                   bypass;
    logic                   ram_wr;
    logic                   rd_issue;
    logic [WORD_WIDTH-1:0]  ram_rd_data;

    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    RAM_Simple_Dual_Port #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .RAMSTYLE   (RAMSTYLE)
    ) u_ram (
        .clock_i   (clock),
        .wr_en_i   (ram_wr),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (input_data),
        .rd_en_i   (rd_issue),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    // Next-state: handshakes, register-stage shuffle, RAM traffic, occupancy and flags.
    always_comb begin
        push = input_valid & in_ready_q;
        pop  = out_valid_q & output_ready;

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (pop) begin
            out_valid_d  = skid_valid_q;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
        end

        // A RAM read issued now lands next cycle, when the stage may not drain;
        // only issue it if the stage holds at most one word after this edge.
        // The same test decides whether a fresh word can skip the RAM.
        room     = !skid_valid_d && !(out_valid_d && rd_pend_q);
        rd_issue = (ram_cnt_q != '0) && room;
        bypass   = push && (ram_cnt_q == '0) && room;
        ram_wr   = push && !bypass;

        // Older RAM word enters the stage before any bypassed word.
        if (rd_pend_q) begin
            if (!out_valid_d) begin
                out_valid_d = 1'b1;
                out_data_d  = ram_rd_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = ram_rd_data;
            end
        end

        if (bypass) begin
            if (!out_valid_d) begin
                out_valid_d = 1'b1;
                out_data_d  = input_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = input_data;
            end
        end

        rd_pend_d = rd_issue;
        wr_ptr_d  = ram_wr   ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = rd_issue ? next_ptr(rd_ptr_q) : rd_ptr_q;

        case ({ram_wr, rd_issue})
            2'b10:   ram_cnt_d = ram_cnt_q + COUNT_WIDTH'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - COUNT_WIDTH'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_WIDTH'(1);
            2'b01:   count_d = count_q - COUNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        in_ready_d = (count_d < FULL_LVL);
        af_d       = (count_d >= AF_LVL);
        ae_d       = (count_d <= AE_LVL);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ram_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            af_q         <= (ALMOST_FULL == 0);
            ae_q         <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ram_cnt_q    <= ram_cnt_d;
            rd_pend_q    <= rd_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            af_q         <= af_d;
            ae_q         <= ae_d;
        end
    end

    assign input_ready  = in_ready_q;
    assign output_valid = out_valid_q;
    assign output_data  = out_data_q;
    assign count        = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule

// File: tb/tb_pipeline_fifo_buffer_fwft.sv
// Bench for pipeline_fifo_buffer_fwft: directed scenarios on a DEPTH=5 instance,
// randomized traffic on DEPTH 2/3/7/16 instances against a ring-buffer model.
module tb_pipeline_fifo_buffer_fwft;

    localparam int DEP [5] = '{5, 2, 3, 7, 16};
    localparam int WORDS   = 10000;

    logic            clk;
    logic            clr;
    logic [4:0]      vin;
    logic [4:0]      ordy;
    logic [7:0]      din [5];
    logic [4:0]      iry;
    logic [4:0]      ov;
    logic [4:0]      af;
    logic [4:0]      ae;
    logic [4:0][7:0] dout;
    logic [4:0][7:0] cnt;

    int checks;
    int errors;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int D  = DEP[g];
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] c;
        pipeline_fifo_buffer_fwft #(
            .WORD_WIDTH   (8),
            .DEPTH        (D),
            .ALMOST_FULL  (D - 1),
            .ALMOST_EMPTY (1),
            .RAMSTYLE     ("M10K")
        ) u_dut (
            .clock        (clk),
            .clear        (clr),
            .input_valid  (vin[g]),
            .input_ready  (iry[g]),
            .input_data   (din[g]),
            .output_valid (ov[g]),
            .output_ready (ordy[g]),
            .output_data  (dout[g]),
            .count        (c),
            .almost_full  (af[g]),
            .almost_empty (ae[g])
        );
        assign cnt[g] = 8'(c);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive instance 0 for one clock edge, return 1 time unit after it.
    task automatic step0(input logic v, input logic [7:0] d, input logic r);
        vin[0]  = v;
        din[0]  = d;
        ordy[0] = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            checks += 6;
            if (cnt[k] !== 8'd0) begin errors++; $display("FAIL reset_count[%0d]: got %0d expected 0", k, cnt[k]); end
            if (iry[k] !== 1'b1) begin errors++; $display("FAIL reset_input_ready[%0d]: got %b expected 1", k, iry[k]); end
            if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_output_valid[%0d]: got %b expected 0", k, ov[k]); end
            if (af[k] !== 1'b0) begin errors++; $display("FAIL reset_almost_full[%0d]: got %b expected 0", k, af[k]); end
            if (ae[k] !== 1'b1) begin errors++; $display("FAIL reset_almost_empty[%0d]: got %b expected 1", k, ae[k]); end
            if (dout[k] !== 8'h00) begin errors++; $display("FAIL reset_output_data[%0d]: got %h expected 00", k, dout[k]); end
        end
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            step0(1'b1, 8'(i), 1'b0);
            checks++;
            if (cnt[0] !== 8'(i)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", cnt[0], i); end
        end
        checks += 3;
        if (iry[0] !== 1'b0) begin errors++; $display("FAIL fill_input_ready: got %b expected 0", iry[0]); end
        if (af[0] !== 1'b1) begin errors++; $display("FAIL fill_almost_full: got %b expected 1", af[0]); end
        if (ae[0] !== 1'b0) begin errors++; $display("FAIL fill_almost_empty: got %b expected 0", ae[0]); end
        step0(1'b1, 8'd6, 1'b0);
        checks++;
        if (cnt[0] !== 8'd5) begin errors++; $display("FAIL fill_sixth_rejected: got count %0d expected 5", cnt[0]); end
        for (int i = 1; i <= 5; i++) begin
            checks += 2;
            if (ov[0] !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b expected 1", ov[0]); end
            if (dout[0] !== 8'(i)) begin errors++; $display("FAIL drain_order: got %0d expected %0d", dout[0], i); end
            step0(1'b0, 8'd0, 1'b1);
        end
        checks += 3;
        if (cnt[0] !== 8'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", cnt[0]); end
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b expected 0", ov[0]); end
        if (ae[0] !== 1'b1) begin errors++; $display("FAIL drain_almost_empty: got %b expected 1", ae[0]); end
    endtask

    task automatic test_latency();
        step0(1'b1, 8'hA5, 1'b0);
        checks += 3;
        if (ov[0] !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b expected 1", ov[0]); end
        if (dout[0] !== 8'hA5) begin errors++; $display("FAIL latency_data: got %h expected a5", dout[0]); end
        if (cnt[0] !== 8'd1) begin errors++; $display("FAIL latency_count: got %0d expected 1", cnt[0]); end
        step0(1'b0, 8'd0, 1'b1);
        checks++;
        if (cnt[0] !== 8'd0) begin errors++; $display("FAIL latency_drain: got %0d expected 0", cnt[0]); end
    endtask

    task automatic test_back_to_back();
        step0(1'b1, 8'd10, 1'b0);
        step0(1'b1, 8'd11, 1'b0);
        for (int i = 0; i < 100; i++) begin
            checks += 3;
            if (cnt[0] !== 8'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", cnt[0]); end
            if (ov[0] !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", ov[0]); end
            if (dout[0] !== 8'(10 + i)) begin errors++; $display("FAIL b2b_order: got %0d expected %0d", dout[0], 10 + i); end
            step0(1'b1, 8'(12 + i), 1'b1);
        end
        for (int i = 110; i < 112; i++) begin
            checks++;
            if (dout[0] !== 8'(i)) begin errors++; $display("FAIL b2b_tail: got %0d expected %0d", dout[0], i); end
            step0(1'b0, 8'd0, 1'b1);
        end
        checks++;
        if (cnt[0] !== 8'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", cnt[0]); end
    endtask

    task automatic test_full_simultaneous();
        for (int i = 21; i <= 25; i++) step0(1'b1, 8'(i), 1'b0);
        checks++;
        if (iry[0] !== 1'b0) begin errors++; $display("FAIL full_input_ready: got %b expected 0", iry[0]); end
        step0(1'b1, 8'd99, 1'b1);
        checks += 3;
        if (cnt[0] !== 8'd4) begin errors++; $display("FAIL full_simul_count: got %0d expected 4", cnt[0]); end
        if (iry[0] !== 1'b1) begin errors++; $display("FAIL full_simul_ready: got %b expected 1", iry[0]); end
        if (dout[0] !== 8'd22) begin errors++; $display("FAIL full_simul_data: got %0d expected 22", dout[0]); end
        for (int i = 22; i <= 25; i++) begin
            checks++;
            if (dout[0] !== 8'(i)) begin errors++; $display("FAIL full_simul_order: got %0d expected %0d", dout[0], i); end
            step0(1'b0, 8'd0, 1'b1);
        end
        checks += 2;
        if (cnt[0] !== 8'd0) begin errors++; $display("FAIL full_simul_drain: got %0d expected 0", cnt[0]); end
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL full_simul_empty: got %b expected 0", ov[0]); end
    endtask

    task automatic test_clear_mid();
        step0(1'b1, 8'd31, 1'b0);
        step0(1'b1, 8'd32, 1'b0);
        step0(1'b1, 8'd33, 1'b0);
        vin[0]  = 1'b0;
        ordy[0] = 1'b0;
        checks++;
        if (cnt[0] !== 8'd3) begin errors++; $display("FAIL clear_pre_count: got %0d expected 3", cnt[0]); end
        #2 clr = 1'b1;
        #1;
        checks += 4;
        if (cnt[0] !== 8'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", cnt[0]); end
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", ov[0]); end
        if (iry[0] !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b expected 1", iry[0]); end
        if (ae[0] !== 1'b1) begin errors++; $display("FAIL clear_almost_empty: got %b expected 1", ae[0]); end
        #2 clr = 1'b0;
        step0(1'b1, 8'h44, 1'b0);
        checks += 3;
        if (ov[0] !== 1'b1) begin errors++; $display("FAIL clear_after_valid: got %b expected 1", ov[0]); end
        if (dout[0] !== 8'h44) begin errors++; $display("FAIL clear_after_data: got %h expected 44", dout[0]); end
        if (cnt[0] !== 8'd1) begin errors++; $display("FAIL clear_after_count: got %0d expected 1", cnt[0]); end
        step0(1'b0, 8'd0, 1'b1);
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL clear_after_drain: got %b expected 0", ov[0]); end
        vin[0]  = 1'b0;
        ordy[0] = 1'b0;
    endtask

    // Random valid/ready on all four random instances at once; model is a
    // ring buffer of accepted words plus an occupancy count.
    task automatic test_random();
        logic [7:0] ring [5][32];
        int head [5], tail [5], mcnt [5], sent [5], recv [5];
        bit ins [5], rem [5];
        int cyc;
        bit done;
        for (int k = 0; k < 5; k++) begin
            head[k] = 0; tail[k] = 0; mcnt[k] = 0; sent[k] = 0; recv[k] = 0;
            ins[k] = 1'b0; rem[k] = 1'b0;
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 60000) begin
            for (int k = 1; k < 5; k++) begin
                checks += 5;
                if (cnt[k] !== 8'(mcnt[k])) begin errors++; $display("FAIL rand_count[D=%0d] cycle %0d: got %0d expected %0d", DEP[k], cyc, cnt[k], mcnt[k]); end
                if (iry[k] !== (mcnt[k] < DEP[k])) begin errors++; $display("FAIL rand_ready[D=%0d] cycle %0d: got %b expected %b", DEP[k], cyc, iry[k], mcnt[k] < DEP[k]); end
                if (ov[k] !== (mcnt[k] > 0)) begin errors++; $display("FAIL rand_valid[D=%0d] cycle %0d: got %b expected %b", DEP[k], cyc, ov[k], mcnt[k] > 0); end
                if (af[k] !== (mcnt[k] >= DEP[k] - 1)) begin errors++; $display("FAIL rand_almost_full[D=%0d] cycle %0d: got %b expected %b", DEP[k], cyc, af[k], mcnt[k] >= DEP[k] - 1); end
                if (ae[k] !== (mcnt[k] <= 1)) begin errors++; $display("FAIL rand_almost_empty[D=%0d] cycle %0d: got %b expected %b", DEP[k], cyc, ae[k], mcnt[k] <= 1); end
                if (mcnt[k] > 0) begin
                    checks++;
                    if (dout[k] !== ring[k][head[k]]) begin errors++; $display("FAIL rand_data[D=%0d] cycle %0d: got %h expected %h", DEP[k], cyc, dout[k], ring[k][head[k]]); end
                end
                vin[k]  = (sent[k] < WORDS) ? 1'($urandom_range(0, 1)) : 1'b0;
                din[k]  = 8'($urandom);
                ordy[k] = 1'($urandom_range(0, 1));
                ins[k]  = vin[k] && (mcnt[k] < DEP[k]);
                rem[k]  = ordy[k] && (mcnt[k] > 0);
            end
            @(posedge clk);
            #1;
            cyc++;
            done = 1'b1;
            for (int k = 1; k < 5; k++) begin
                if (rem[k]) begin
                    head[k] = (head[k] + 1) % 32;
                    mcnt[k]--;
                    recv[k]++;
                end
                if (ins[k]) begin
                    ring[k][tail[k]] = din[k];
                    tail[k] = (tail[k] + 1) % 32;
                    mcnt[k]++;
                    sent[k]++;
                end
                if (recv[k] < WORDS) done = 1'b0;
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL rand_timeout: got %0d cycles without completing, expected all %0d words drained", cyc, WORDS); end
        for (int k = 1; k < 5; k++) begin
            vin[k]  = 1'b0;
            ordy[k] = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr    = 1'b1;
        vin    = '0;
        ordy   = '0;
        for (int k = 0; k < 5; k++) din[k] = 8'd0;
        test_reset();
        test_fill_drain();
        test_latency();
        test_back_to_back();
        test_full_simultaneous();
        test_clear_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
